msx_port_arbiter: RTL and testbench

- Parametrised successor of the fixed two-port joystick/mouse selection in the MSX top level.
- Takes NPORTS logical joystick words plus one PS/2 mouse, and drives NPORTS active-low 6-bit MSX general-purpose port vectors.
- Per-port mouse ownership is tracked automatically. Ports can be reversed with a swap control, and the OSD can mask inputs.
- Sits between the hps_io/DB9 joystick muxing and the emsx_top pJoyA/pJoyB/pStrA/pStrB pins.

---
 rtl/msx_port_pkg.sv | 27 ++
 rtl/msx_port_mode_fsm.sv | 43 ++++
 rtl/msx_port_arbiter.sv | 125 ++++++++++++
 tb/tb_msx_port_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/msx_port_pkg.sv
// -----------------------------------------------------------------------------
// msx_port_pkg
// Shared types and helpers for the MSX general-purpose port arbiter.
//   msx_pins_t    : one active-low MSX port vector, [5]F2 [4]F1 [3]R [2]L [1]D [0]U
//   MSX_PINS_IDLE : all pins released
//   port_mode_e   : per-port ownership, joystick or mouse
//   joy_to_msx    : joystick word (active-high [0]R [1]L [2]D [3]U [4]F1 [5]F2)
//                   to active-low MSX pin vector
// -----------------------------------------------------------------------------
package msx_port_pkg;

    typedef logic [5:0] msx_pins_t;

    localparam msx_pins_t MSX_PINS_IDLE = 6'h3F;

    typedef enum logic {
        PM_JOY   = 1'b0,
        PM_MOUSE = 1'b1
    } port_mode_e;

    // Reorders the joystick bits into MSX pin order and inverts them, since
    // the MSX side pulls a pin low for a pressed direction or button.
    function automatic msx_pins_t joy_to_msx(input logic [15:0] joy);
        return ~{joy[5], joy[4], joy[0], joy[1], joy[2], joy[3]};
    endfunction

endpackage

// File: rtl/msx_port_mode_fsm.sv
// -----------------------------------------------------------------------------
// msx_port_mode_fsm
// JOY/MOUSE ownership state machine for a single MSX port.
//   clk_sys    in  system clock
//   reset      in  synchronous, active-high
//   enable     in  this port is the one the mouse may own
//   mouse_edge in  a new PS/2 mouse packet arrived this cycle
//   joy_act    in  joystick activity on this port (after OSD masking)
//   force_joy  in  drop to JOY unconditionally (select change / idle timeout)
//   mode       out current ownership state (registered)
// -----------------------------------------------------------------------------
module msx_port_mode_fsm
    import msx_port_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       enable,
    input  logic       mouse_edge,
    input  logic       joy_act,
    input  logic       force_joy,
    output port_mode_e mode
);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mode <= PM_JOY;
        end else begin
            case (mode)
                // Joystick activity beats a simultaneous mouse packet.
                PM_JOY: begin
                    if (enable && mouse_edge && !joy_act && !force_joy)
                        mode <= PM_MOUSE;
                end
                PM_MOUSE: begin
                    if (!enable || joy_act || force_joy)
                        mode <= PM_JOY;
                end
                default: mode <= PM_JOY;
            endcase
        end
    end

endmodule

// File: rtl/msx_port_arbiter.sv
// -----------------------------------------------------------------------------
// msx_port_arbiter
// Maps NPORTS joystick words plus one PS/2 mouse onto NPORTS active-low MSX
// general-purpose port vectors, tracking which port (if any) the mouse owns.
//   clk_sys        in  system clock
//   reset          in  synchronous, active-high
//   joy_in         in  NPORTS*16 joystick words, port p at [16p+15:16p]
//   swap           in  logical port p takes physical joystick NPORTS-1-p
//   osd_active     in  OSD open, joystick inputs treated as released
//   mouse_port_sel in  port the mouse may own (values >= NPORTS disable mouse)
//   ps2_mouse_stb  in  PS/2 mouse packet toggle
//   mdata          in  active-low mouse pin data
//   strobe_in      in  pin-8 strobe per port
//   mouse_strobe   out strobe of the selected port (registered)
//   port_out       out NPORTS*6 active-low MSX pins (registered)
//   mouse_active   out one-hot, port currently in mouse mode
// Optional build macro MSX_PORT_MOUSE_TIMEOUT_EN adds a mouse-idle timeout of
// MOUSE_IDLE_CYCLES clk_sys cycles; without it MOUSE_IDLE_CYCLES is ignored.
// -----------------------------------------------------------------------------
module msx_port_arbiter
    import msx_port_pkg::*;
#(
    parameter int          NPORTS            = 2,
    parameter int          SELW              = (NPORTS > 2) ? $clog2(NPORTS) : 1,
    parameter logic [31:0] MOUSE_IDLE_CYCLES = 32'd214_000_000
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic [NPORTS*16-1:0]  joy_in,
    input  logic                  swap,
    input  logic                  osd_active,
    input  logic [SELW-1:0]       mouse_port_sel,
    input  logic                  ps2_mouse_stb,
    input  logic [5:0]            mdata,
    input  logic [NPORTS-1:0]     strobe_in,
    output logic                  mouse_strobe,
    output logic [NPORTS*6-1:0]   port_out,
    output logic [NPORTS-1:0]     mouse_active
);

    logic              stb_q;
    logic [SELW-1:0]   sel_q;
    logic              mouse_edge;
    logic              sel_changed;
    logic              timeout;
    logic              force_joy;
    logic [NPORTS-1:0] sel_hit;
    logic [NPORTS-1:0] joy_act;
    logic [5:0]        joy_low [NPORTS];
    msx_pins_t         pins    [NPORTS];
    port_mode_e        mode    [NPORTS];
    logic [NPORTS*10-1:0] unused_joy_hi;

    assign mouse_edge  = stb_q ^ ps2_mouse_stb;
    assign sel_changed = (mouse_port_sel != sel_q);
    assign force_joy   = sel_changed | timeout;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        localparam int PHYS_FWD = p;
        localparam int PHYS_REV = NPORTS - 1 - p;

        // Swap first, then OSD masking, so activity detection sees the
        // joystick exactly as the MSX side would.
        assign joy_low[p] = osd_active ? 6'h00
                          : (swap ? joy_in[16*PHYS_REV +: 6] : joy_in[16*PHYS_FWD +: 6]);
        assign unused_joy_hi[10*p +: 10] = joy_in[16*p+6 +: 10];

        assign pins[p]    = joy_to_msx({10'h000, joy_low[p]});
        assign joy_act[p] = |joy_low[p];

        // Out-of-range selects match no port, so nobody can take the mouse.
        assign sel_hit[p] = (mouse_port_sel == SELW'(p));

        msx_port_mode_fsm u_mode_fsm (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .enable     (sel_hit[p]),
            .mouse_edge (mouse_edge),
            .joy_act    (joy_act[p]),
            .force_joy  (force_joy),
            .mode       (mode[p])
        );

        assign mouse_active[p] = (mode[p] == PM_MOUSE);
    end

`ifdef MSX_PORT_MOUSE_TIMEOUT_EN
    logic [31:0] idle_cnt;

    // A packet arriving on the expiry cycle counts as activity and wins.
    assign timeout = (|mouse_active) && !mouse_edge
                  && (idle_cnt == MOUSE_IDLE_CYCLES - 32'd1);

    always_ff @(posedge clk_sys) begin
        if (reset || mouse_edge || !(|mouse_active) || timeout)
            idle_cnt <= 32'd0;
        else if (idle_cnt != 32'hFFFF_FFFF)
            idle_cnt <= idle_cnt + 32'd1;
    end
`else
    logic [31:0] unused_idle_cfg;

    assign timeout         = 1'b0;
    assign unused_idle_cfg = MOUSE_IDLE_CYCLES;
`endif

    // Edge trackers follow their inputs even in reset so that leaving reset
    // never looks like a mouse packet or a select change.
    always_ff @(posedge clk_sys) begin
        stb_q <= ps2_mouse_stb;
        sel_q <= mouse_port_sel;
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            port_out     <= {NPORTS{MSX_PINS_IDLE}};
            mouse_strobe <= 1'b0;
        end else begin
            for (int p = 0; p < NPORTS; p++)
                port_out[6*p +: 6] <= mouse_active[p] ? mdata : pins[p];
            mouse_strobe <= |(sel_hit & strobe_in);
        end
    end

endmodule

// File: tb/tb_msx_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_msx_port_arbiter
// Directed walk through the main scenarios followed by randomized traffic,
// all checked cycle by cycle against a behavioural model that tracks the
// mouse owner as a plain port number.
// -----------------------------------------------------------------------------
module tb_msx_port_arbiter;

    localparam int NP       = 2;
    localparam int IDLE_LIM = 100;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic [NP*16-1:0] joy_in;
    logic            swap;
    logic            osd_active;
    logic [0:0]      mouse_port_sel;
    logic            ps2_mouse_stb;
    logic [5:0]      mdata;
    logic [NP-1:0]   strobe_in;
    logic            mouse_strobe;
    logic [NP*6-1:0] port_out;
    logic [NP-1:0]   mouse_active;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int             m_owner;      // -1: no port owns the mouse
    logic [NP*6-1:0] m_port_out;
    logic           m_strobe;
    logic           m_stb_prev;
    int             m_sel_prev;
    int             m_idle;

    msx_port_arbiter #(
        .NPORTS            (NP),
        .MOUSE_IDLE_CYCLES (32'(IDLE_LIM))
    ) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .joy_in         (joy_in),
        .swap           (swap),
        .osd_active     (osd_active),
        .mouse_port_sel (mouse_port_sel),
        .ps2_mouse_stb  (ps2_mouse_stb),
        .mdata          (mdata),
        .strobe_in      (strobe_in),
        .mouse_strobe   (mouse_strobe),
        .port_out       (port_out),
        .mouse_active   (mouse_active)
    );

    // ---------------------------------------------------------------- clock
    always #5 clk_sys = ~clk_sys;

    // ---------------------------------------------------------------- check
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // MSX pins written out by name: a pressed control pulls its pin low.
    function automatic logic [5:0] msx_pins(input logic [5:0] j);
        logic right, left, down, up, f1, f2;
        right = j[0]; left = j[1]; down = j[2]; up = j[3]; f1 = j[4]; f2 = j[5];
        return {!f2, !f1, !right, !left, !down, !up};
    endfunction

    function automatic logic [NP-1:0] owner_mask(input int owner);
        logic [NP-1:0] m;
        m = '0;
        if (owner >= 0) m[owner] = 1'b1;
        return m;
    endfunction

    task automatic model_step();
        logic [5:0]      j [NP];
        logic [NP*6-1:0] nxt_out;
        logic            nxt_strobe;
        int              nxt_owner;
        int              nxt_idle;
        int              sel;
        int              src;
        bit              pkt;
        bit              expired;

        sel = int'(mouse_port_sel);
        pkt = (ps2_mouse_stb != m_stb_prev);
        for (int p = 0; p < NP; p++) begin
            src  = swap ? (NP - 1 - p) : p;
            j[p] = osd_active ? 6'h00 : joy_in[16*src +: 6];
        end
        for (int p = 0; p < NP; p++)
            nxt_out[6*p +: 6] = (m_owner == p) ? mdata : msx_pins(j[p]);
        nxt_strobe = (sel < NP) ? strobe_in[sel] : 1'b0;

`ifdef MSX_PORT_MOUSE_TIMEOUT_EN
        expired = (m_owner >= 0) && !pkt && (m_idle == IDLE_LIM - 1);
        nxt_idle = (pkt || m_owner < 0 || expired) ? 0 : m_idle + 1;
`else
        expired  = 1'b0;
        nxt_idle = 0;
`endif

        nxt_owner = m_owner;
        if (reset) begin
            nxt_owner  = -1;
            nxt_out    = '1;
            nxt_strobe = 1'b0;
            nxt_idle   = 0;
        end else if (sel != m_sel_prev || sel >= NP) begin
            nxt_owner = -1;
        end else if (j[sel] != 6'h00 || expired) begin
            nxt_owner = -1;
        end else if (pkt) begin
            nxt_owner = sel;
        end

        m_owner    = nxt_owner;
        m_port_out = nxt_out;
        m_strobe   = nxt_strobe;
        m_idle     = nxt_idle;
        m_stb_prev = ps2_mouse_stb;
        m_sel_prev = sel;
    endtask

    // ---------------------------------------------------------------- driver
    // Advances one clock with the current inputs and compares every output.
    task automatic step_cycle();
        model_step();
        @(posedge clk_sys);
        #1;
        check("port_out", 32'(port_out), 32'(m_port_out));
        check("mouse_active", 32'(mouse_active), 32'(owner_mask(m_owner)));
        check("mouse_strobe", 32'(mouse_strobe), 32'(m_strobe));
        check("onehot", 32'($countones(mouse_active) <= 1), 32'd1);
    endtask

    task automatic toggle_stb();
        ps2_mouse_stb = ~ps2_mouse_stb;
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        reset          = 1'b1;
        joy_in         = '0;
        swap           = 1'b0;
        osd_active     = 1'b0;
        mouse_port_sel = 1'b0;
        ps2_mouse_stb  = 1'b0;
        mdata          = 6'h3F;
        strobe_in      = '0;
        m_owner        = -1;
        m_port_out     = '1;
        m_strobe       = 1'b0;
        m_stb_prev     = 1'b0;
        m_sel_prev     = 0;
        m_idle         = 0;

        // 1. reset then idle
        step_cycle();
        step_cycle();
        reset = 1'b0;
        step_cycle();
        check("rst_port_out", 32'(port_out), 32'hFFF);
        check("rst_mouse_active", 32'(mouse_active), 32'h0);
        check("rst_mouse_strobe", 32'(mouse_strobe), 32'h0);

        // 2. pin mapping and swap
        joy_in = {16'h0000, 16'h0011};
        step_cycle();
        check("map_p0", 32'(port_out[5:0]), 32'h27);
        check("map_p1", 32'(port_out[11:6]), 32'h3F);
        swap = 1'b1;
        step_cycle();
        check("swap_p1", 32'(port_out[11:6]), 32'h27);
        check("swap_p0", 32'(port_out[5:0]), 32'h3F);
        joy_in = '0;
        swap   = 1'b0;
        step_cycle();

        // 3. mouse takes port 1
        mouse_port_sel = 1'b1;
        step_cycle();
        toggle_stb();
        mdata = 6'h15;
        step_cycle();
        check("mouse_take", 32'(mouse_active), 32'h2);
        strobe_in = 2'b10;
        step_cycle();
        check("mouse_data", 32'(port_out[11:6]), 32'h15);
        check("mouse_strobe_fwd", 32'(mouse_strobe), 32'h1);
        strobe_in = 2'b00;

        // 4. joystick beats a simultaneous mouse packet
        joy_in = {16'h0004, 16'h0000};
        toggle_stb();
        step_cycle();
        check("joy_wins", 32'(mouse_active), 32'h0);
        step_cycle();
        check("joy_wins_pins", 32'(port_out[11:6]), 32'h3D);
        joy_in = '0;
        step_cycle();

        // 5. select change drops the mouse; OSD masks activity
        toggle_stb();
        step_cycle();
        check("retake", 32'(mouse_active), 32'h2);
        mouse_port_sel = 1'b0;
        step_cycle();
        check("sel_change", 32'(mouse_active), 32'h0);
        mouse_port_sel = 1'b1;
        step_cycle();
        toggle_stb();
        step_cycle();
        osd_active = 1'b1;
        joy_in     = {16'h003F, 16'h003F};
        step_cycle();
        step_cycle();
        check("osd_keeps_mouse", 32'(mouse_active), 32'h2);
        check("osd_pins_p0", 32'(port_out[5:0]), 32'h3F);
        osd_active = 1'b0;
        step_cycle();
        check("osd_off_drop", 32'(mouse_active), 32'h0);
        joy_in = '0;
        step_cycle();

        // 6. idle behaviour
        toggle_stb();
        step_cycle();
`ifdef MSX_PORT_MOUSE_TIMEOUT_EN
        for (int i = 0; i < IDLE_LIM - 1; i++) step_cycle();
        check("idle_before", 32'(mouse_active), 32'h2);
        step_cycle();
        check("idle_expired", 32'(mouse_active), 32'h0);
`else
        for (int i = 0; i < 1000; i++) step_cycle();
        check("idle_persist", 32'(mouse_active), 32'h2);
`endif

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < NP; p++)
                joy_in[16*p +: 16] = ($urandom_range(0, 5) == 0) ? 16'($urandom)
                                   : {10'($urandom), 6'h00};
            if ($urandom_range(0, 7) == 0)  swap = ~swap;
            osd_active = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 15) == 0) mouse_port_sel = 1'($urandom);
            if ($urandom_range(0, 3) == 0)  toggle_stb();
            mdata     = 6'($urandom);
            strobe_in = 2'($urandom);
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
